// File: rtl/shift_ctrl_pkg.sv
// Shared types and widths for the LED shift-register control stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift_ctrl_pkg;

    // FSM encoding; values are fixed so they match waveform decoders.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int CNT_W = 5;   // width of shift_cnt
    localparam int PRE_W = 24;  // width of the tick prescaler

endpackage

// File: rtl/shift_ctrl_debounce.sv
// Button conditioner: 2-flop synchronizer, optional stability filter, rising-edge pulse.
// Latency: 2 + DB_CYCLES + 1 cycles with SHIFT_CTRL_DEBOUNCE_EN, otherwise 3 cycles.
// Backpressure: none; press is a single-cycle pulse per accepted rising edge.
module debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic sync0;
    logic sync1;
    logic level;
    logic level_q;

    // Bring the raw button into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= btn;
            sync1 <= sync0;
        end
    end

`ifdef SHIFT_CTRL_DEBOUNCE_EN
    localparam int DB_W = $clog2(DB_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [DB_W-1:0] stab_cnt;

    // Accept a new level only after it has differed from the current one for DB_CYCLES cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stab_cnt <= '0;
            level    <= 1'b0;
        end else if (sync1 == level) begin
            stab_cnt <= '0;
        end else if (stab_cnt == DB_LAST) begin
            stab_cnt <= '0;
            level    <= sync1;
        end else begin
            stab_cnt <= stab_cnt + 1'b1;
        end
    end
`else
    // Fast-simulation build: the synchronized level is used directly.
    assign level = sync1;
`endif

    // Registered rising-edge detect on the accepted level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
            press   <= 1'b0;
        end else begin
            level_q <= level;
            press   <= level & ~level_q;
        end
    end

endmodule

// File: rtl/shift_ctrl.sv
// Load/run sequencer for the 16-bit LED register: buttons -> SP select and counted tick enables.
// Latency: press to state change 1 cycle; first tick DIV_MAX+1 cycles after entering LOAD/RUN.
// Backpressure: none; stop aborts at any time. Debounce filter built when SHIFT_CTRL_DEBOUNCE_EN is defined.
module shift_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int DIV_MAX     = 12_499_999,
    parameter int DB_CYCLES   = 1_000_000,
    parameter int SHIFT_LIMIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_load,
    input  logic             btn_run,
    input  logic             btn_stop,
    output logic             SP,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] shift_cnt
);

    localparam logic [PRE_W-1:0] DIV_LAST = PRE_W'(DIV_MAX);
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(SHIFT_LIMIT);

    logic press_load;
    logic press_run;
    logic press_stop;

    state_t           state;
    state_t           state_nxt;
    logic [PRE_W-1:0] pre_cnt;
    logic [PRE_W-1:0] pre_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             wrap;

    debounce #(.DB_CYCLES(DB_CYCLES)) u_db_load (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_load),
        .press (press_load)
    );

    debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_run),
        .press (press_run)
    );

    debounce #(.DB_CYCLES(DB_CYCLES)) u_db_stop (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_stop),
        .press (press_stop)
    );

    assign wrap = (pre_cnt == DIV_LAST);

    // Next state, tick and shift count; stop has priority over everything, including a wrap.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = shift_cnt;
        tick      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!press_stop) begin
                    if (press_load) begin
                        state_nxt = LOAD;
                    end else if (press_run) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end
                end
            end
            LOAD: begin
                if (press_stop) begin
                    state_nxt = IDLE;
                end else if (wrap) begin
                    tick      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (press_stop) begin
                    state_nxt = IDLE;
                end else if (wrap) begin
                    tick    = 1'b1;
                    cnt_nxt = shift_cnt + 1'b1;
                    // Limit 0 means free-running; the 5-bit count simply rolls over.
                    if ((SHIFT_LIMIT != 0) && (cnt_nxt == LIMIT)) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Prescaler restarts on every state change so each LOAD/RUN gets a full first period.
    always_comb begin
        pre_nxt = '0;
        if ((state_nxt == state) && (state != IDLE)) begin
            pre_nxt = wrap ? '0 : pre_cnt + 1'b1;
        end
    end

    // State, prescaler, count and the registered SP/busy outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pre_cnt   <= '0;
            shift_cnt <= '0;
            SP        <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            pre_cnt   <= pre_nxt;
            shift_cnt <= cnt_nxt;
            SP        <= (state_nxt == LOAD);
            busy      <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_shift_ctrl.sv
// Self-checking bench for shift_ctrl: directed tables, multi-cycle corner sequences, random vs model.
// Latency: n/a.
// Backpressure: n/a.
module tb_shift_ctrl;

    localparam int DIVM = 3;
    localparam int DBC  = 4;
`ifdef SHIFT_CTRL_DEBOUNCE_EN
    localparam int LAT  = 2 + DBC + 1;
    localparam bit DBEN = 1'b1;
`else
    localparam int LAT  = 3;
    localparam bit DBEN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] btn_a = 3'b000;   // [0] load, [1] run, [2] stop
    logic [2:0] btn_b = 3'b000;
    logic       sp_a, tick_a, busy_a, sp_b, tick_b, busy_b;
    logic [4:0] cnt_a, cnt_b;

    always #5 clk = ~clk;

    shift_ctrl #(.DIV_MAX(DIVM), .DB_CYCLES(DBC), .SHIFT_LIMIT(16)) dut_a (
        .clk(clk), .rst(rst), .btn_load(btn_a[0]), .btn_run(btn_a[1]), .btn_stop(btn_a[2]),
        .SP(sp_a), .tick(tick_a), .busy(busy_a), .shift_cnt(cnt_a)
    );

    shift_ctrl #(.DIV_MAX(DIVM), .DB_CYCLES(DBC), .SHIFT_LIMIT(0)) dut_b (
        .clk(clk), .rst(rst), .btn_load(btn_b[0]), .btn_run(btn_b[1]), .btn_stop(btn_b[2]),
        .SP(sp_b), .tick(tick_b), .busy(busy_b), .shift_cnt(cnt_b)
    );

    int cyc  = 0;
    int nchk = 0;
    int nerr = 0;

    typedef struct {
        int         scen;
        int         off;   // sample offset from the entry edge into LOAD/RUN
        logic       sp;
        logic       tick;
        logic       busy;
        logic [4:0] cnt;
    } vec_t;

    vec_t tbl[$];

    bit rise_mem[3][0:4095];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] outs(input int sel);
        return (sel != 0) ? {sp_b, tick_b, busy_b, cnt_b} : {sp_a, tick_a, busy_a, cnt_a};
    endfunction

    task automatic set_btn(input int sel, input int b, input logic v);
        if (sel != 0) btn_b[b] = v;
        else          btn_a[b] = v;
    endtask

    // Press main_b at the current sample, optionally a second button whose press pulse lands at sec_off.
    task automatic run_scen(input int scen, input int sel, input int main_b, input int sec_b, input int sec_off);
        int k, e, last, sec_at;
        logic [7:0] o;
        k      = cyc;
        e      = k + LAT + 1;
        last   = 0;
        sec_at = e + sec_off - LAT;
        foreach (tbl[i]) if (tbl[i].scen == scen && tbl[i].off > last) last = tbl[i].off;
        while (cyc <= e + last) begin
            o = outs(sel);
            foreach (tbl[i]) begin
                if (tbl[i].scen == scen && tbl[i].off == cyc - e) begin
                    chk($sformatf("s%0d_off%0d_sp", scen, tbl[i].off), 32'(o[7]), 32'(tbl[i].sp));
                    chk($sformatf("s%0d_off%0d_tick", scen, tbl[i].off), 32'(o[6]), 32'(tbl[i].tick));
                    chk($sformatf("s%0d_off%0d_busy", scen, tbl[i].off), 32'(o[5]), 32'(tbl[i].busy));
                    chk($sformatf("s%0d_off%0d_cnt", scen, tbl[i].off), 32'(o[4:0]), 32'(tbl[i].cnt));
                end
            end
            if (cyc == k)      set_btn(sel, main_b, 1'b1);
            if (cyc == k + 10) set_btn(sel, main_b, 1'b0);
            if (sec_b >= 0) begin
                if (cyc == sec_at)      set_btn(sel, sec_b, 1'b1);
                if (cyc == sec_at + 10) set_btn(sel, sec_b, 1'b0);
            end
            step();
        end
        set_btn(sel, main_b, 1'b0);
        if (sec_b >= 0) set_btn(sel, sec_b, 1'b0);
        repeat (20) step();
    endtask

    initial begin
        int k, e_exp, npress, r, base;
        bit bad;
        int mode, entry, mcnt;
        int lvl[3];
        int left[3];
        bit p[3];
        bit wrap_e, tick_e, busy_e, sp_e;

        // Scenario 0: load, with a run press one cycle into LOAD that must be ignored.
        tbl.push_back('{0, -1, 0, 0, 0, 0});
        tbl.push_back('{0,  0, 1, 0, 1, 0});
        tbl.push_back('{0,  2, 1, 0, 1, 0});
        tbl.push_back('{0,  3, 1, 1, 1, 0});
        tbl.push_back('{0,  4, 0, 0, 0, 0});
        tbl.push_back('{0,  8, 0, 0, 0, 0});
        // Scenario 1: full 16-shift run, load press at offset 21 ignored.
        tbl.push_back('{1,  0, 0, 0, 1, 0});
        tbl.push_back('{1,  3, 0, 1, 1, 0});
        tbl.push_back('{1,  4, 0, 0, 1, 1});
        tbl.push_back('{1,  7, 0, 1, 1, 1});
        tbl.push_back('{1, 21, 0, 0, 1, 5});
        tbl.push_back('{1, 22, 0, 0, 1, 5});
        tbl.push_back('{1, 59, 0, 1, 1, 14});
        tbl.push_back('{1, 63, 0, 1, 1, 15});
        tbl.push_back('{1, 64, 0, 0, 0, 16});
        tbl.push_back('{1, 70, 0, 0, 0, 16});
        // Scenario 2: stop coincides with the 5th wrap.
        tbl.push_back('{2,  0, 0, 0, 1, 0});
        tbl.push_back('{2, 15, 0, 1, 1, 3});
        tbl.push_back('{2, 19, 0, 0, 1, 4});
        tbl.push_back('{2, 20, 0, 0, 0, 4});
        tbl.push_back('{2, 24, 0, 0, 0, 4});
        // Scenario 3: unlimited run on the second instance, 40 ticks then stop.
        tbl.push_back('{3,   3, 0, 1, 1, 0});
        tbl.push_back('{3, 124, 0, 0, 1, 31});
        tbl.push_back('{3, 128, 0, 0, 1, 0});
        tbl.push_back('{3, 159, 0, 1, 1, 7});
        tbl.push_back('{3, 160, 0, 0, 1, 8});
        tbl.push_back('{3, 162, 0, 0, 0, 8});

        // Reset state.
        step();
        chk("rst_sp", 32'(sp_a), 0);
        chk("rst_tick", 32'(tick_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_cnt", 32'(cnt_a), 0);
        rst = 1'b0;
        repeat (5) step();

        run_scen(0, 0, 0, 1, 1);
        run_scen(1, 0, 1, 0, 21);
        run_scen(2, 0, 1, 2, 19);
        run_scen(3, 1, 1, 2, 161);

        // Reset asserted mid-run forces everything back immediately.
        k = cyc;
        btn_a[1] = 1'b1;
        while (cyc < k + LAT + 1 + 9) step();
        chk("midrun_cnt_before", 32'(cnt_a), 2);
        rst = 1'b1;
        #1;
        chk("midrst_sp", 32'(sp_a), 0);
        chk("midrst_tick", 32'(tick_a), 0);
        chk("midrst_busy", 32'(busy_a), 0);
        chk("midrst_cnt", 32'(cnt_a), 0);
        step();
        btn_a[1] = 1'b0;
        step();
        rst = 1'b0;
        bad = 1'b0;
        repeat (100) begin
            step();
            if (outs(0) != 8'd0) bad = 1'b1;
        end
        chk("idle_100_outputs_zero", 32'(bad), 0);

        // Bouncing run button: toggle every 2 cycles for 20 cycles, then hold.
        k      = cyc;
        npress = 0;
        e_exp  = DBEN ? k + 20 + LAT + 1 : k + LAT + 1;
        while (cyc <= e_exp + 20) begin
            if (dut_a.press_run) npress++;
            if (cyc == e_exp - 1) chk("bounce_busy_before", 32'(busy_a), 0);
            if (cyc == e_exp)     chk("bounce_busy_entry", 32'(busy_a), 1);
            if (cyc == e_exp + 1) chk("bounce_sp_run", 32'(sp_a), 0);
            if (cyc == e_exp + 20) begin
                chk("bounce_busy_later", 32'(busy_a), 1);
                chk("bounce_cnt_later", 32'(cnt_a), 5);
            end
            r = cyc - k;
            btn_a[1] = (r < 20) ? ((r % 4) < 2) : (r < 35);
            step();
        end
        btn_a[1] = 1'b0;
        chk("bounce_press_count", npress, DBEN ? 1 : 6);
        for (int i = 0; i < 200 && busy_a; i++) step();
        chk("bounce_run_done", 32'(busy_a), 0);
        chk("bounce_run_cnt", 32'(cnt_a), 16);

        // Random button traffic against a cycle-index model.
        rst = 1'b1;
        step();
        rst  = 1'b0;
        base = cyc;
        mode = 0; entry = 0; mcnt = 0;
        for (int b = 0; b < 3; b++) begin
            lvl[b]  = 0;
            left[b] = $urandom_range(40, 200);
        end
        for (r = 0; r < 3000; r++) begin
            for (int b = 0; b < 3; b++) p[b] = (r >= LAT) ? rise_mem[b][r - LAT] : 1'b0;
            busy_e = (mode != 0);
            sp_e   = (mode == 1);
            wrap_e = busy_e && (((r - entry) % (DIVM + 1)) == DIVM);
            tick_e = wrap_e && !p[2];
            chk($sformatf("rand_r%0d_sp_tick_busy_cnt", r), 32'(outs(0)), 32'({sp_e, tick_e, busy_e, 5'(mcnt)}));
            if (mode == 0) begin
                if (p[2]) begin
                end else if (p[0]) begin
                    mode = 1; entry = r + 1;
                end else if (p[1]) begin
                    mode = 2; entry = r + 1; mcnt = 0;
                end
            end else if (mode == 1) begin
                if (p[2] || wrap_e) mode = 0;
            end else begin
                if (p[2]) mode = 0;
                else if (wrap_e) begin
                    mcnt = (mcnt + 1) % 32;
                    if (mcnt == 16) mode = 0;
                end
            end
            for (int b = 0; b < 3; b++) begin
                left[b]--;
                if (left[b] <= 0) begin
                    lvl[b] = 1 - lvl[b];
                    if (lvl[b] == 1) begin
                        rise_mem[b][r] = 1'b1;
                        left[b] = $urandom_range(6, 12);
                    end else begin
                        left[b] = (b == 2) ? $urandom_range(100, 400) : $urandom_range(40, 250);
                    end
                end
                btn_a[b] = (lvl[b] == 1);
            end
            step();
        end
        if (cyc - base != 3000) chk("rand_cycle_count", cyc - base, 3000);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
